// File: rtl/sys_timer.sv
// sys_timer: 64-bit cycle / time / instret counters with a zero-latency CSR read mux.
// Optional macro SYS_TIMER_SNAPSHOT_EN adds a shared upper-half shadow for consistent 64-bit reads.
module sys_timer #(
  parameter int unsigned TIME_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  input  logic        rd_en,
  input  logic [1:0]  timer,
  input  logic        upper,
  output logic [31:0] data
);

  localparam int unsigned CNT_W  = 64;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned PRE_W  = 16;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIME_DIV - 1);

  localparam logic [1:0] SEL_CYCLE   = 2'd0;
  localparam logic [1:0] SEL_TIME    = 2'd1;
  localparam logic [1:0] SEL_INSTRET = 2'd2;

  logic [CNT_W-1:0]  cyc;
  logic [CNT_W-1:0]  tim;
  logic [CNT_W-1:0]  ins;
  logic [PRE_W-1:0]  pre;
  logic              tick_c;
  logic [CNT_W-1:0]  sel_c;
  logic              sel_valid_c;
  logic [HALF_W-1:0] hi_c;

  // Prescaler terminal count; with TIME_DIV=1 the prescaler stays at 0 and ticks every cycle.
  assign tick_c = (pre == PRE_LAST);

  // Full-width increments so the bit-31 carry lands in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= '0;
      tim <= '0;
      ins <= '0;
      pre <= '0;
    end else begin
      cyc <= cyc + CNT_W'(1);
      pre <= tick_c ? '0 : pre + PRE_W'(1);
      if (tick_c) begin
        tim <= tim + CNT_W'(1);
      end
      if (retire) begin
        ins <= ins + CNT_W'(1);
      end
    end
  end

  // Counter select; the reserved encoding selects nothing.
  always_comb begin
    sel_c       = '0;
    sel_valid_c = 1'b0;
    case (timer)
      SEL_CYCLE: begin
        sel_c       = cyc;
        sel_valid_c = 1'b1;
      end
      SEL_TIME: begin
        sel_c       = tim;
        sel_valid_c = 1'b1;
      end
      SEL_INSTRET: begin
        sel_c       = ins;
        sel_valid_c = 1'b1;
      end
      default: begin
        sel_c       = '0;
        sel_valid_c = 1'b0;
      end
    endcase
  end

`ifdef SYS_TIMER_SNAPSHOT_EN
  logic [HALF_W-1:0] shadow;

  // A low-half read latches the matching upper half so the follow-up read is consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (rd_en && !upper && sel_valid_c) begin
      shadow <= sel_c[CNT_W-1:HALF_W];
    end
  end

  assign hi_c = shadow;
`else
  logic unused_rd_en;

  assign unused_rd_en = rd_en;
  assign hi_c         = sel_c[CNT_W-1:HALF_W];
`endif

  // Read data is purely combinational from the current register values.
  always_comb begin
    data = '0;
    if (sel_valid_c) begin
      data = upper ? hi_c : sel_c[HALF_W-1:0];
    end
  end

endmodule
